short_preamble_gen: RTL

SHORT_PREAMBLE_GEN -- requirements
Module: short_preamble_gen

---
 rtl/ofdm_pkg.sv | 37 +++
 rtl/short_preamble_gen_sts_rom.sv | 33 +++
 rtl/short_preamble_gen.sv | 130 +++++++++++++
 3 files changed

// File: rtl/ofdm_pkg.sv
// Shared OFDM constants: default generator parameters, preamble FSM state
// encoding and the 802.11a short training symbol tables.
//   STS_I/STS_Q : 16-entry time-domain short training symbol, scaled by 8192
//                 and rounded, two's complement on STS_TBL_W bits.
package ofdm_pkg;

    localparam int unsigned DEF_IQ_WIDTH   = 16;
    localparam int unsigned DEF_STS_LENGTH = 16;
    localparam int unsigned DEF_NUM_REPS   = 10;

    localparam int unsigned STS_TBL_LEN = 16;
    localparam int unsigned STS_TBL_W   = 16;
    localparam int unsigned STS_ADDR_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        FINISH = 2'd2
    } sts_state_e;

    // In-phase component of one short training symbol period.
    localparam logic signed [STS_TBL_W-1:0] STS_I [STS_TBL_LEN] = '{
          16'sd377, -16'sd1081,  -16'sd106,  16'sd1171,
          16'sd754,  16'sd1171,  -16'sd106, -16'sd1081,
          16'sd377,    16'sd16,  -16'sd647,  -16'sd106,
            16'sd0,  -16'sd106,  -16'sd647,    16'sd16
    };

    // Quadrature component of one short training symbol period.
    localparam logic signed [STS_TBL_W-1:0] STS_Q [STS_TBL_LEN] = '{
          16'sd377,    16'sd16,  -16'sd647,  -16'sd106,
            16'sd0,  -16'sd106,  -16'sd647,    16'sd16,
          16'sd377, -16'sd1081,  -16'sd106,  16'sd1171,
          16'sd754,  16'sd1171,  -16'sd106, -16'sd1081
    };

endpackage

// File: rtl/short_preamble_gen_sts_rom.sv
// sts_rom: registered short-training-symbol lookup.
// Ports:
//   CLK   - clock
//   s_RST - synchronous active-high reset
//   zero  - force the registered outputs to zero on the next edge
//   addr  - table index (sample within the symbol period)
//   a_i   - registered in-phase sample
//   a_q   - registered quadrature sample
module sts_rom
    import ofdm_pkg::*;
#(
    parameter int unsigned I_Q_Width = DEF_IQ_WIDTH
) (
    input  logic                  CLK,
    input  logic                  s_RST,
    input  logic                  zero,
    input  logic [STS_ADDR_W-1:0] addr,
    output logic [I_Q_Width-1:0]  a_i,
    output logic [I_Q_Width-1:0]  a_q
);

    // Table entries are signed, so the width cast sign-extends.
    always_ff @(posedge CLK) begin
        if (s_RST || zero) begin
            a_i <= '0;
            a_q <= '0;
        end else begin
            a_i <= I_Q_Width'(STS_I[addr]);
            a_q <= I_Q_Width'(STS_Q[addr]);
        end
    end

endmodule

// File: rtl/short_preamble_gen.sv
// short_preamble_gen: emits one 802.11a short preamble burst per start request
// (NUM_REPS repetitions of an STS_LENGTH-sample symbol) with ready/strobe
// handshaking.
// Ports:
//   CLK, s_RST       - clock, synchronous active-high reset
//   enable           - low clears the block like s_RST
//   start            - single-cycle burst request (ignored unless idle)
//   out_ready        - downstream accepts the current sample
//   a_i, a_q         - signed I/Q sample
//   output_strobe    - a_i/a_q valid
//   sym_start        - first sample of each symbol period
//   busy             - burst in progress (EMIT or FINISH)
//   done             - one-cycle pulse after the final transfer
module short_preamble_gen
    import ofdm_pkg::*;
#(
    parameter int unsigned I_Q_Width  = DEF_IQ_WIDTH,
    parameter int unsigned STS_LENGTH = DEF_STS_LENGTH,
    parameter int unsigned NUM_REPS   = DEF_NUM_REPS
) (
    input  logic                 CLK,
    input  logic                 s_RST,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 out_ready,
    output logic [I_Q_Width-1:0] a_i,
    output logic [I_Q_Width-1:0] a_q,
    output logic                 output_strobe,
    output logic                 sym_start,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned SAMP_W = (STS_LENGTH > 1) ? $clog2(STS_LENGTH) : 1;
    localparam int unsigned REP_W  = $clog2(NUM_REPS) + 1;
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(STS_LENGTH - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(NUM_REPS - 1);

    sts_state_e        state, state_nxt;
    logic [SAMP_W-1:0] samp_cnt, samp_nxt;
    logic [REP_W-1:0]  rep_cnt, rep_nxt;
    logic              clear;
    logic              rom_zero;
    logic [STS_ADDR_W-1:0] rom_addr;

    assign clear = s_RST || !enable;

    // Next-state and counter logic; a transfer is EMIT with out_ready high.
    always_comb begin
        state_nxt = state;
        samp_nxt  = samp_cnt;
        rep_nxt   = rep_cnt;
        if (clear) begin
            state_nxt = IDLE;
            samp_nxt  = '0;
            rep_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = EMIT;
                        samp_nxt  = '0;
                        rep_nxt   = '0;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (samp_cnt == SAMP_LAST) begin
                            samp_nxt = '0;
                            if (rep_cnt == REP_LAST) begin
                                state_nxt = FINISH;
                                rep_nxt   = '0;
                            end else begin
                                rep_nxt = rep_cnt + REP_W'(1);
                            end
                        end else begin
                            samp_nxt = samp_cnt + SAMP_W'(1);
                        end
                    end
                end
                FINISH: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                    samp_nxt  = '0;
                    rep_nxt   = '0;
                end
            endcase
        end
    end

    // The ROM is addressed with the next sample index so its registered
    // output lines up with samp_cnt; outside EMIT it is forced to zero.
    assign rom_addr = STS_ADDR_W'(samp_nxt);
    assign rom_zero = (state_nxt != EMIT);

    // State, counters and registered status outputs.
    always_ff @(posedge CLK) begin
        if (s_RST) begin
            state         <= IDLE;
            samp_cnt      <= '0;
            rep_cnt       <= '0;
            output_strobe <= 1'b0;
            sym_start     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            samp_cnt      <= samp_nxt;
            rep_cnt       <= rep_nxt;
            output_strobe <= (state_nxt == EMIT);
            sym_start     <= (state_nxt == EMIT) && (samp_nxt == '0);
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == FINISH);
        end
    end

    sts_rom #(
        .I_Q_Width(I_Q_Width)
    ) u_sts_rom (
        .CLK  (CLK),
        .s_RST(s_RST),
        .zero (rom_zero),
        .addr (rom_addr),
        .a_i  (a_i),
        .a_q  (a_q)
    );

endmodule
